fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter sharing the asynchronous FIFO's write side among NUM_REQ requesters in the write clock domain. Grants one requester at a time, muxes its data onto the FIFO write port, honours full/almost_full back-pressure and limits each tenure to a configurable burst length. Sits directly in front of the FIFO write interface; the read side is untouched.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_WIDTH, 8: FIFO word width
- BURST_LEN, 4: max beats per grant tenure, ≥1
- wr_clk  in  1  write-domain clock; single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level, held while data valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- full  in  1  FIFO full (write domain)
- almost_full  in  1  FIFO almost-full (write domain)
- gnt  out  NUM_REQ  registered one-hot grant
- ack  out  NUM_REQ  one-hot, combinational; beat accepted this cycle
- wr_en  out  1  FIFO write enable, combinational
- wdata  out  DATA_WIDTH  FIFO write data, combinational mux
- owner  out  $clog2(NUM_REQ)  registered index of current or last owner

## Operation
- States: ARB_IDLE, ARB_XFER.
- ARB_IDLE: if any req and !full and !almost_full, select first requesting index after last owner (cyclic), register gnt/owner, clear beat count, go ARB_XFER. Otherwise stay; gnt=0.
- ARB_XFER: beat = req[owner] & !full. On beat: wr_en=1, wdata=req_data[owner], ack[owner]=1, count++.
- Release (gnt→0, state→ARB_IDLE, last owner kept) on any of: beat taking count to BURST_LEN; req[owner]=0 (no write that cycle).
- full in ARB_XFER: no write, count and grant held (stall), no timeout.
- almost_full gates only new grants; an active tenure continues until full.
- Non-owner requests are never acked; requester must hold req and data until ack.
- Count width $clog2(BURST_LEN+1), never wraps; compare is equality.

## Timing
- Reset (async assert, sync release on wr_clk): state ARB_IDLE, gnt=0, owner=NUM_REQ-1 (requester 0 wins first), count=0; wr_en=0, ack=0, wdata=0.
- Request to first write: 1 cycle (grant registered on edge after req seen, write in following cycle).
- Back-to-back writes within a tenure: 1 per cycle while !full.
- Release to next grant: one ARB_IDLE bubble cycle, always.
- Simultaneous release and new request from same requester: it is lowest priority in next arbitration.
- Reset mid-tenure: gnt, wr_en, ack drop immediately; partial burst abandoned, no write.

## Configuration
- FIFO_ARB_BURST_EN defined: tenure up to BURST_LEN beats as above.
- Undefined: BURST_LEN ignored; every grant releases after exactly one beat (effective BURST_LEN=1), count logic removed, strict per-beat round-robin with 50% peak throughput.

## Structure
- Shared FIFO RTL package: arb_state_e {ARB_IDLE, ARB_XFER} typedef, default NUM_REQ/BURST_LEN constants alongside existing DATA_WIDTH definitions.
- One sub-module: fifo_rr_pick, combinational round-robin selector (req vector, last index in → valid, next index out).

## Test plan
- Reset, req=4'b0001, full=0: gnt=0001 after 1 cycle, 4 writes of req_data[0] on consecutive cycles, release, bubble, re-grant to 0.
- req=4'b1111, BURST_LEN=4: grant order 0,1,2,3,0; each tenure exactly 4 wr_en, one idle cycle between.
- Owner 2 mid-burst, full high 3 cycles after beat 2: wr_en=0 for 3 cycles, count stays 2, then beats 3–4 complete.
- almost_full=1 in ARB_IDLE with req=4'b0010: no grant until almost_full=0; active tenure ignores almost_full.
- req[1] drops after beat 1: no write that cycle, release, next grant to next requester after 1.
- rst pulsed during beat 3 of requester 3: gnt/wr_en immediately 0; after release requester 0 granted first; macro undefined: every tenure exactly 1 beat.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FIFO package: default geometry constants and the write-arbiter state type.
package fifo_wr_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_BURST_LEN  = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: first requesting index strictly after `last`, wrapping.
module fifo_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] next
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Walk from the farthest offset down so the nearest requester after `last` wins.
  always_comb begin
    valid = 1'b0;
    next  = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NUM_REQ]) begin
        valid = 1'b1;
        next  = IDX_W'((int'(last) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
// FIFO_ARB_BURST_EN: when defined, tenures last up to BURST_LEN beats; otherwise one beat each.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  input  logic                          almost_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0]   owner_nxt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               beat;
  logic               last_beat;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req),
    .last  (owner),
    .valid (pick_vld),
    .next  (pick_idx)
  );

  assign beat = (state == ARB_XFER) && req[owner] && !full;

`ifdef FIFO_ARB_BURST_EN
  localparam int               CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

  logic [CNT_W-1:0] count, count_nxt, count_inc;

  assign count_inc = count + CNT_W'(1);
  assign last_beat = (count_inc == CNT_LAST);

  // Count is zeroed while idle so every new tenure starts from zero; stalls hold it.
  always_comb begin
    count_nxt = count;
    if (state == ARB_IDLE) begin
      count_nxt = '0;
    end else if (beat) begin
      count_nxt = count_inc;
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    wr_en     = 1'b0;
    ack       = '0;
    wdata     = '0;
    case (state)
      ARB_IDLE: begin
        // almost_full only blocks new tenures; it never interrupts one in progress.
        if (pick_vld && !full && !almost_full) begin
          gnt_nxt   = NUM_REQ'(1) << pick_idx;
          owner_nxt = pick_idx;
          state_nxt = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (beat) begin
          wr_en      = 1'b1;
          ack[owner] = 1'b1;
          wdata      = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        end
        if (!req[owner] || (beat && last_beat)) begin
          gnt_nxt   = '0;
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Reset owner to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
    end
  end

endmodule
